// File: rtl/btb_predictor.sv
// Branch target buffer for next-PC selection in IF.
// Direct-mapped, indexed by PC word address, with a 2-bit saturating
// counter per entry. Lookup is combinational from registered state.
// Updates from EX land on the next rising edge and are never bypassed.
module btb_predictor #(
    parameter int XLEN            = 32,
    parameter int BTB_SIZE        = 64,
    parameter int BTB_INDEX_WIDTH = $clog2(BTB_SIZE),
    parameter int BTB_TAG_WIDTH   = XLEN - BTB_INDEX_WIDTH - 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic [1:0]      pred_state_o,
    input  logic            upd_en_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic [XLEN-1:0] upd_target_i,
    input  logic            upd_taken_i,
    input  logic            upd_is_jump_i
);

    typedef enum logic [1:0] {
        PRED_STRONG_NOT_TAKEN = 2'b00,
        PRED_WEAK_NOT_TAKEN   = 2'b01,
        PRED_WEAK_TAKEN       = 2'b10,
        PRED_STRONG_TAKEN     = 2'b11
    } pred_state_e;

    // Only the valid bits are reset; the payload is meaningless while invalid.
    logic [BTB_SIZE-1:0]      valid_q;
    logic [BTB_SIZE-1:0]      jump_q;
    logic [BTB_TAG_WIDTH-1:0] tag_q    [BTB_SIZE];
    logic [XLEN-1:0]          target_q [BTB_SIZE];
    logic [1:0]               ctr_q    [BTB_SIZE];

    logic [BTB_INDEX_WIDTH-1:0] lk_idx;
    logic [BTB_TAG_WIDTH-1:0]   lk_tag;
    logic                       lk_hit;

    logic [BTB_INDEX_WIDTH-1:0] upd_idx;
    logic [BTB_TAG_WIDTH-1:0]   upd_tag;
    logic                       upd_hit;
    logic                       upd_fire;
    logic [1:0]                 upd_ctr_cur;
    logic [1:0]                 upd_ctr_inc;
    logic [1:0]                 upd_ctr_dec;

    // Byte offset within the instruction word never affects the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    assign lk_idx  = lookup_pc_i[BTB_INDEX_WIDTH+1:2];
    assign lk_tag  = lookup_pc_i[XLEN-1:BTB_INDEX_WIDTH+2];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign upd_idx  = upd_pc_i[BTB_INDEX_WIDTH+1:2];
    assign upd_tag  = upd_pc_i[XLEN-1:BTB_INDEX_WIDTH+2];
    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_fire = upd_en_i && !flush_i;

    // Saturating neighbours of the counter being updated; never wrap.
    always_comb begin
        upd_ctr_cur = ctr_q[upd_idx];
        upd_ctr_inc = (upd_ctr_cur == PRED_STRONG_TAKEN) ? upd_ctr_cur : upd_ctr_cur + 2'd1;
        upd_ctr_dec = (upd_ctr_cur == PRED_STRONG_NOT_TAKEN) ? upd_ctr_cur : upd_ctr_cur - 2'd1;
    end

    // Prediction for IF: hit entry contents, or all-zero miss response.
    always_comb begin
        pred_valid_o  = 1'b0;
        pred_taken_o  = 1'b0;
        pred_target_o = '0;
        pred_state_o  = PRED_STRONG_NOT_TAKEN;
        if (lk_hit) begin
            pred_valid_o  = 1'b1;
            pred_taken_o  = jump_q[lk_idx] | ctr_q[lk_idx][1];
            pred_target_o = target_q[lk_idx];
            pred_state_o  = ctr_q[lk_idx];
        end
    end

    // Valid bits: async reset, flush wins over allocation of a new entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (upd_en_i && !upd_hit && upd_taken_i) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Entry payload: train on hits, allocate on taken misses.
    always_ff @(posedge clk) begin
        if (upd_fire) begin
            if (upd_hit) begin
                if (upd_is_jump_i) begin
                    target_q[upd_idx] <= upd_target_i;
                    ctr_q[upd_idx]    <= PRED_STRONG_TAKEN;
                    jump_q[upd_idx]   <= 1'b1;
                end else if (upd_taken_i) begin
                    target_q[upd_idx] <= upd_target_i;
                    ctr_q[upd_idx]    <= upd_ctr_inc;
                end else begin
                    ctr_q[upd_idx]    <= upd_ctr_dec;
                end
            end else if (upd_taken_i) begin
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target_i;
                jump_q[upd_idx]   <= upd_is_jump_i;
                ctr_q[upd_idx]    <= upd_is_jump_i ? PRED_STRONG_TAKEN : PRED_WEAK_TAKEN;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor. The stimulus process pushes the
// hand-computed prediction for each checked cycle into a queue; a separate
// monitor pops and compares on the falling edge whenever a lookup is marked.
module tb_btb_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] lookup_pc_i = '0;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [1:0]  pred_state_o;
    logic        upd_en_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic [31:0] upd_target_i = '0;
    logic        upd_taken_i = 1'b0;
    logic        upd_is_jump_i = 1'b0;

    logic        lookup_req = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    typedef struct {
        string       name;
        logic        valid;
        logic        taken;
        logic [31:0] target;
        logic [1:0]  state;
    } exp_t;

    exp_t sb_q[$];

    btb_predictor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .lookup_pc_i   (lookup_pc_i),
        .pred_valid_o  (pred_valid_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .pred_state_o  (pred_state_o),
        .upd_en_i      (upd_en_i),
        .upd_pc_i      (upd_pc_i),
        .upd_target_i  (upd_target_i),
        .upd_taken_i   (upd_taken_i),
        .upd_is_jump_i (upd_is_jump_i)
    );

    always #5 clk = ~clk;

    // Compare one popped expectation against the live prediction outputs.
    task automatic checkOutput(input exp_t e);
        vectors++;
        if (pred_valid_o !== e.valid || pred_taken_o !== e.taken ||
            pred_target_o !== e.target || pred_state_o !== e.state) begin
            miscompares++;
            $display("[TB] FAIL %s: got v=%b t=%b tgt=%h st=%b, expected v=%b t=%b tgt=%h st=%b",
                     e.name, pred_valid_o, pred_taken_o, pred_target_o, pred_state_o,
                     e.valid, e.taken, e.target, e.state);
        end
    endtask

    // Monitor: every marked lookup cycle consumes one scoreboard entry.
    always @(negedge clk) begin
        if (lookup_req) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
            end else begin
                checkOutput(sb_q.pop_front());
            end
        end
    end

    // One cycle of stimulus: drive lookup and update, optionally expect a result.
    task automatic applyStimulus(input string name, input logic [31:0] pc, input bit chk,
                                 input logic ev, input logic et, input logic [31:0] etgt,
                                 input logic [1:0] est, input logic ue, input logic [31:0] upc,
                                 input logic [31:0] utgt, input logic ut, input logic uj,
                                 input logic fl);
        exp_t e;
        @(posedge clk);
        #1;
        lookup_pc_i   = pc;
        upd_en_i      = ue;
        upd_pc_i      = upc;
        upd_target_i  = utgt;
        upd_taken_i   = ut;
        upd_is_jump_i = uj;
        flush_i       = fl;
        lookup_req    = chk;
        if (chk) begin
            e.name = name; e.valid = ev; e.taken = et; e.target = etgt; e.state = est;
            sb_q.push_back(e);
        end
    endtask

    task automatic expectMiss(input string name, input logic [31:0] pc);
        applyStimulus(name, pc, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expectHit(input string name, input logic [31:0] pc, input logic et,
                             input logic [31:0] etgt, input logic [1:0] est);
        applyStimulus(name, pc, 1'b1, 1'b1, et, etgt, est, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic updateOnly(input logic [31:0] upc, input logic [31:0] utgt,
                              input logic ut, input logic uj);
        applyStimulus("", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, upc, utgt, ut, uj, 1'b0);
    endtask

    // Lookup at 0x100 while training it; the result shows the pre-update entry.
    task automatic trainAndSee(input string name, input logic [31:0] utgt, input logic ut,
                               input logic et, input logic [31:0] etgt, input logic [1:0] est);
        applyStimulus(name, 32'h100, 1'b1, 1'b1, et, etgt, est, 1'b1, 32'h100, utgt, ut, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state while reset is held.
        expectMiss("reset_lookup", 32'h0000_0100);
        @(posedge clk); #1; rst_n = 1'b1; lookup_req = 1'b0;

        // Allocate branch; same-cycle lookup still misses.
        applyStimulus("alloc_no_bypass", 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00,
                      1'b1, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0);
        // Counter walk down and up; not-taken never rewrites the target.
        trainAndSee("ctr_weak_taken",  32'h999, 1'b0, 1'b1, 32'h180, 2'b10);
        trainAndSee("ctr_weak_nt",     32'h999, 1'b0, 1'b0, 32'h180, 2'b01);
        trainAndSee("ctr_strong_nt",   32'h999, 1'b0, 1'b0, 32'h180, 2'b00);
        trainAndSee("ctr_sat_low",     32'h180, 1'b1, 1'b0, 32'h180, 2'b00);
        trainAndSee("ctr_up_1",        32'h184, 1'b1, 1'b0, 32'h180, 2'b01);
        trainAndSee("ctr_up_2",        32'h188, 1'b1, 1'b1, 32'h184, 2'b10);
        trainAndSee("ctr_up_3",        32'h18c, 1'b1, 1'b1, 32'h188, 2'b11);
        expectHit("ctr_sat_high", 32'h100, 1'b1, 32'h18c, 2'b11);

        // Aliasing at index 0 and eviction.
        expectMiss("alias_miss", 32'h1100);
        applyStimulus("evict_no_bypass", 32'h1100, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00,
                      1'b1, 32'h1100, 32'h40, 1'b1, 1'b0, 1'b0);
        expectHit("evict_new", 32'h1100, 1'b1, 32'h40, 2'b10);
        expectHit("pc_low_bits_ignored", 32'h1102, 1'b1, 32'h40, 2'b10);
        expectMiss("evicted_old", 32'h100);

        // Not-taken miss never allocates.
        updateOnly(32'h304, 32'h500, 1'b0, 1'b0);
        expectMiss("nt_no_alloc", 32'h304);

        // Jump entry: always taken even after a not-taken branch update.
        updateOnly(32'h200, 32'h300, 1'b1, 1'b1);
        expectHit("jal_alloc", 32'h200, 1'b1, 32'h300, 2'b11);
        updateOnly(32'h200, 32'h999, 1'b0, 1'b0);
        expectHit("jal_after_nt", 32'h200, 1'b1, 32'h300, 2'b10);
        updateOnly(32'h200, 32'h340, 1'b1, 1'b1);
        expectHit("jal_retarget", 32'h200, 1'b1, 32'h340, 2'b11);

        // Flush beats a simultaneous update.
        updateOnly(32'h104, 32'h500, 1'b1, 1'b0);
        expectHit("pre_flush", 32'h104, 1'b1, 32'h500, 2'b10);
        applyStimulus("flush_no_bypass", 32'h104, 1'b1, 1'b1, 1'b1, 32'h500, 2'b10,
                      1'b1, 32'h108, 32'h600, 1'b1, 1'b0, 1'b1);
        expectMiss("flush_104", 32'h104);
        expectMiss("flush_200", 32'h200);
        expectMiss("flush_upd_dropped", 32'h108);

        // Mid-test reset pulse with an update in flight.
        updateOnly(32'h10c, 32'h700, 1'b1, 1'b0);
        expectHit("pre_reset", 32'h10c, 1'b1, 32'h700, 2'b10);
        applyStimulus("async_reset", 32'h10c, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00,
                      1'b1, 32'h110, 32'h800, 1'b1, 1'b0, 1'b0);
        #2; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1; upd_en_i = 1'b0; lookup_req = 1'b0;
        expectMiss("reset_cleared", 32'h10c);
        expectMiss("reset_upd_dropped", 32'h110);

        @(posedge clk); #1; lookup_req = 1'b0; upd_en_i = 1'b0;
        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
